// File: rtl/k2red_iter_mult.sv
// Digit-serial a*b multiplier feeding the K2-RED reducer: one DIG_W-bit digit of b per cycle,
// with Q and l1/l2/l3 carried alongside so the reducer sees an aligned result bundle.
module k2red_iter_mult #(
    parameter int LOG_Q = 64,
    parameter int DIG_W = 16,
    parameter int LOG_L = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LOG_Q-1:0]     a,
    input  logic [LOG_Q-1:0]     b,
    input  logic [LOG_Q-1:0]     Q,
    input  logic [LOG_L-1:0]     l1,
    input  logic [LOG_L-1:0]     l2,
    input  logic [LOG_L-1:0]     l3,
    output logic                 out_valid,
    output logic [2*LOG_Q-1:0]   A,
    output logic [LOG_Q-1:0]     Q_o,
    output logic [LOG_L-1:0]     l1_o,
    output logic [LOG_L-1:0]     l2_o,
    output logic [LOG_L-1:0]     l3_o
);

    localparam int NDIG  = LOG_Q / DIG_W;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PP_W  = LOG_Q + DIG_W;
    localparam int ACC_W = 2 * LOG_Q;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [LOG_Q-1:0]   r_a;
    logic [LOG_Q-1:0]   r_b;
    logic [LOG_Q-1:0]   r_q;
    logic [LOG_L-1:0]   r_l1;
    logic [LOG_L-1:0]   r_l2;
    logic [LOG_L-1:0]   r_l3;

    logic [DIG_W-1:0]   w_digits [NDIG];
    logic [DIG_W-1:0]   w_digit;
    logic [31:0]        w_shamt;
    logic [PP_W-1:0]    w_pp;
    logic [ACC_W-1:0]   w_pp_sh;
    logic [ACC_W-1:0]   w_sum;
    logic               w_accept;

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
            assign w_digits[gi] = r_b[gi*DIG_W +: DIG_W];
        end
    endgenerate

    assign w_digit  = w_digits[r_cnt];
    assign w_shamt  = 32'(r_cnt) * 32'(DIG_W);
    // Partial product never exceeds LOG_Q+DIG_W bits, and the running sum stays below 2^(2*LOG_Q).
    assign w_pp     = {{DIG_W{1'b0}}, r_a} * {{LOG_Q{1'b0}}, w_digit};
    assign w_pp_sh  = ACC_W'(w_pp) << w_shamt;
    assign w_sum    = r_acc + w_pp_sh;

    assign in_ready = ((r_state == S_IDLE) || (r_state == S_DONE)) && !rst;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            out_valid <= 1'b0;
            A         <= '0;
            Q_o       <= '0;
            l1_o      <= '0;
            l2_o      <= '0;
            l3_o      <= '0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_q     <= Q;
                        r_l1    <= l1;
                        r_l2    <= l2;
                        r_l3    <= l3;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_MUL;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    r_acc <= w_sum;
                    if (r_cnt == LAST_CNT) begin
                        r_cnt     <= '0;
                        A         <= w_sum;
                        Q_o       <= r_q;
                        l1_o      <= r_l1;
                        l2_o      <= r_l2;
                        l3_o      <= r_l3;
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_k2red_iter_mult.sv
// Directed bench for k2red_iter_mult: a cycle-level countdown model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_k2red_iter_mult;

    localparam int LOG_Q = 64;
    localparam int DIG_W = 16;
    localparam int LOG_L = 4;
    localparam int NDIG  = LOG_Q / DIG_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [LOG_Q-1:0]   a, b, Q;
    logic [LOG_L-1:0]   l1, l2, l3;
    logic               out_valid;
    logic [2*LOG_Q-1:0] A;
    logic [LOG_Q-1:0]   Q_o;
    logic [LOG_L-1:0]   l1_o, l2_o, l3_o;

    always #5 clk = ~clk;

    k2red_iter_mult #(
        .LOG_Q(LOG_Q),
        .DIG_W(DIG_W),
        .LOG_L(LOG_L)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .Q        (Q),
        .l1       (l1),
        .l2       (l2),
        .l3       (l3),
        .out_valid(out_valid),
        .A        (A),
        .Q_o      (Q_o),
        .l1_o     (l1_o),
        .l2_o     (l2_o),
        .l3_o     (l3_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a result appears NDIG edges after an accept; new bundles are taken whenever nothing is pending.
    int           m_rem = 0;
    bit           m_ov  = 1'b0;
    bit           m_chk = 1'b0;
    logic [127:0] m_A   = '0;
    logic [63:0]  m_Q   = '0;
    logic [3:0]   m_l1  = '0, m_l2 = '0, m_l3 = '0;
    logic [63:0]  p_a, p_b, p_Q;
    logic [3:0]   p_l1, p_l2, p_l3;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_chk = 1'b1;
                m_rem = 0;
                m_ov  = 1'b0;
                m_A   = '0;
                m_Q   = '0;
                m_l1  = '0;
                m_l2  = '0;
                m_l3  = '0;
            end else begin
                m_ov = 1'b0;
                if (m_rem > 0) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_ov = 1'b1;
                        m_A  = {64'b0, p_a} * {64'b0, p_b};
                        m_Q  = p_Q;
                        m_l1 = p_l1;
                        m_l2 = p_l2;
                        m_l3 = p_l3;
                    end
                end else if (in_valid) begin
                    p_a   = a;
                    p_b   = b;
                    p_Q   = Q;
                    p_l1  = l1;
                    p_l2  = l2;
                    p_l3  = l3;
                    m_rem = NDIG;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_chk) begin
                chk("cyc_in_ready", in_ready, (m_rem == 0) && !rst);
                chk("cyc_out_valid", out_valid, m_ov);
                chk("cyc_A", A, m_A);
                chk("cyc_Q_o", Q_o, m_Q);
                chk("cyc_l1_o", l1_o, m_l1);
                chk("cyc_l2_o", l2_o, m_l2);
                chk("cyc_l3_o", l3_o, m_l3);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input logic [63:0] ia, input logic [63:0] ib,
                          input logic [63:0] iq, input logic [3:0] i1, input logic [3:0] i2,
                          input logic [3:0] i3);
        in_valid = v;
        a  = ia;
        b  = ib;
        Q  = iq;
        l1 = i1;
        l2 = i2;
        l3 = i3;
    endtask

    // exp_n counts negedges from the call until out_valid is seen.
    task automatic wait_out(input string name, input int exp_n, input logic [127:0] eA,
                            input logic [63:0] eQ, input logic [3:0] e1, input logic [3:0] e2,
                            input logic [3:0] e3);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        chk({name, "_seen"}, 128'(seen), 128'd1);
        if (seen) begin
            chk({name, "_lat"}, 128'(n), 128'(exp_n));
            chk({name, "_A"}, A, eA);
            chk({name, "_modelA"}, m_A, eA);
            chk({name, "_Q_o"}, Q_o, eQ);
            chk({name, "_l1_o"}, l1_o, e1);
            chk({name, "_l2_o"}, l2_o, e2);
            chk({name, "_l3_o"}, l3_o, e3);
        end
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int hits = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (out_valid !== 1'b0) hits++;
        end
        chk(name, 128'(hits), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        set_in(1'b0, '0, '0, '0, '0, '0, '0);
        repeat (2) tick();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_A", A, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // 1: small operands, latency and sideband capture
        tick();
        set_in(1'b1, 64'd3, 64'd5, 64'h1, 4'd2, 4'd3, 4'd4);
        tick();
        in_valid = 1'b0;
        wait_out("t1", 5, 128'd15, 64'h1, 4'd2, 4'd3, 4'd4);
        tick();

        // 2: all-ones operands exercise every digit shift and the top-word carry
        set_in(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 4'd1, 4'd1, 4'd1);
        tick();
        in_valid = 1'b0;
        wait_out("t2", 5, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 64'h1234, 4'd1, 4'd1, 4'd1);
        tick();

        // 3: back-to-back bundles under continuous in_valid
        set_in(1'b1, 64'd7, 64'd9, 64'hA, 4'd5, 4'd6, 4'd7);
        tick();
        set_in(1'b1, 64'd0, 64'hDEAD, 64'hB, 4'd8, 4'd9, 4'd10);
        fork
            begin
                repeat (5) tick();
                set_in(1'b1, 64'h8000_0000_0000_0000, 64'd2, 64'hC, 4'd11, 4'd12, 4'd13);
                repeat (5) tick();
                in_valid = 1'b0;
            end
            begin
                wait_out("t3a", 5, 128'd63, 64'hA, 4'd5, 4'd6, 4'd7);
                wait_out("t3b", 5, 128'd0, 64'hB, 4'd8, 4'd9, 4'd10);
                wait_out("t3c", 5, 128'h1_0000_0000_0000_0000, 64'hC, 4'd11, 4'd12, 4'd13);
            end
        join
        tick();

        // 4: new bundles offered during MUL must be ignored
        set_in(1'b1, 64'd11, 64'd13, 64'hD, 4'd1, 4'd2, 4'd3);
        tick();
        fork
            begin
                set_in(1'b1, 64'd999, 64'd777, 64'hEE, 4'd15, 4'd15, 4'd15);
                tick();
                in_valid = 1'b0;
                tick();
                set_in(1'b1, 64'd555, 64'd444, 64'hFF, 4'd14, 4'd14, 4'd14);
                tick();
                in_valid = 1'b0;
            end
            wait_out("t4", 5, 128'd143, 64'hD, 4'd1, 4'd2, 4'd3);
        join
        tick();

        // 5: reset during the second MUL cycle aborts the operation
        set_in(1'b1, 64'd100, 64'd200, 64'h5, 4'd4, 4'd5, 4'd6);
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_ready_after_rst", in_ready, 1);
        chk("t5_A_cleared", A, 0);
        chk("t5_Q_o_cleared", Q_o, 0);
        chk("t5_l1_o_cleared", l1_o, 0);
        expect_quiet("t5_no_out", 8);
        tick();
        set_in(1'b1, 64'd21, 64'd2, 64'h7, 4'd3, 4'd2, 4'd1);
        tick();
        in_valid = 1'b0;
        wait_out("t5_next", 5, 128'd42, 64'h7, 4'd3, 4'd2, 4'd1);
        tick();

        // 6: reset wins over a simultaneous accept
        rst = 1'b1;
        set_in(1'b1, 64'd50, 64'd60, 64'h9, 4'd9, 4'd9, 4'd9);
        #1;
        chk("t6_ready_in_rst", in_ready, 0);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        expect_quiet("t6_no_out", 10);
        chk("t6_A_zero", A, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
